// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and operand classification.
package fp32_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[FRAC_W +: EXP_W] == 8'hFF) && (x[FRAC_W-1:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[FRAC_W +: EXP_W] == 8'hFF) && (x[FRAC_W-1:0] == '0);
    endfunction

    // Denormals share exp=0 with zero and are flushed along with it.
    function automatic logic is_zero(input logic [31:0] x);
        return x[FRAC_W +: EXP_W] == 8'h00;
    endfunction
endpackage

// File: rtl/fp_lzc27.sv
// Combinational leading-zero counter over a 27-bit significand+G+R+S word.
module fp_lzc27 (
    input  logic [26:0] din,
    output logic [4:0]  cnt
);
    logic found;

    always_comb begin
        cnt   = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && din[i]) begin
                cnt   = 5'(26 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_adder.sv
// Binary32 adder: combinational align/add/normalize/RNE-round, one enabled
// output register. Flush-to-zero on denormal inputs and underflowing results.
module fp_adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        en,
    output logic [31:0] sum
);
    logic [31:0] op_l, op_s;
    logic [7:0]  e_l, e_s, de;
    logic [23:0] m_l, m_s;
    logic [49:0] sh_ext;
    logic [26:0] l_al, s_al, diff27, norm;
    logic [27:0] add28;
    logic [4:0]  lz;
    logic        eff_sub, rnd_up;
    logic [24:0] mant_r;
    logic [22:0] frac_r;
    logic [9:0]  exp_n, exp_r;
    logic [31:0] result, sum_d, sum_q;

    // Larger magnitude becomes L; sign of result follows L.
    always_comb begin
        if (operand_1[30:0] >= operand_2[30:0]) begin
            op_l = operand_1;
            op_s = operand_2;
        end else begin
            op_l = operand_2;
            op_s = operand_1;
        end
    end

    assign e_l     = op_l[FRAC_W +: EXP_W];
    assign e_s     = op_s[FRAC_W +: EXP_W];
    assign de      = e_l - e_s;
    assign m_l     = {1'b1, op_l[FRAC_W-1:0]};
    assign m_s     = {1'b1, op_s[FRAC_W-1:0]};
    assign eff_sub = op_l[31] ^ op_s[31];

    // Bits [49:24] land as significand+G+R; everything below folds into sticky.
    assign sh_ext = {m_s, 26'd0} >> de;
    assign s_al   = (de >= 8'd26) ? 27'd1 : {sh_ext[49:24], |sh_ext[23:0]};
    assign l_al   = {m_l, 3'b000};
    assign add28  = {1'b0, l_al} + {1'b0, s_al};
    assign diff27 = l_al - s_al;

    fp_lzc27 u_lzc (
        .din (diff27),
        .cnt (lz)
    );

    always_comb begin
        norm  = add28[26:0];
        exp_n = {2'b00, e_l};
        if (eff_sub) begin
            norm  = diff27 << lz;
            exp_n = {2'b00, e_l} - {5'd0, lz};
        end else if (add28[27]) begin
            norm  = {add28[27:2], add28[1] | add28[0]};
            exp_n = {2'b00, e_l} + 10'd1;
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        exp_r  = mant_r[24] ? exp_n + 10'd1 : exp_n;
        frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

        // exp_n is negative (bit 9) or zero when normalization underflows.
        if (eff_sub && diff27 == 27'd0)
            result = 32'h00000000;
        else if (exp_n[9] || exp_n == 10'd0)
            result = {op_l[31], 31'd0};
        else if (exp_r >= 10'(EXP_MAX))
            result = op_l[31] ? NEG_INF : POS_INF;
        else
            result = {op_l[31], exp_r[7:0], frac_r};

        if (is_nan(operand_1) || is_nan(operand_2) ||
            (is_inf(operand_1) && is_inf(operand_2) && (operand_1[31] != operand_2[31])))
            result = QNAN;
        else if (is_inf(operand_1))
            result = operand_1;
        else if (is_inf(operand_2))
            result = operand_2;
        else if (is_zero(operand_1) && is_zero(operand_2))
            result = {operand_1[31] & operand_2[31], 31'd0};
        else if (is_zero(operand_1))
            result = operand_2;
        else if (is_zero(operand_2))
            result = operand_1;
    end

    assign sum_d = en ? result : sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= 32'h00000000;
        else        sum_q <= sum_d;
    end

    assign sum = sum_q;
endmodule

// File: tb/tb_fp_adder.sv
// Directed vector bench for fp_adder: table of hand-computed sums plus reset,
// hold and back-to-back sequences.
module tb_fp_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        en = 1'b0;
    logic [31:0] sum;

    int total = 0;
    int bad   = 0;

    fp_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .en        (en),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] want);
        total++;
        if (sum !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, sum, want);
        end
    endtask

    initial begin
        vecs[0]  = '{"add_1p0",      32'h3F800000, 32'h3C449BA6, 32'h3F818937};
        vecs[1]  = '{"add_3p10",     32'h40400000, 32'h41200000, 32'h41500000};
        vecs[2]  = '{"add_frac",     32'h3EA00000, 32'h3F600000, 32'h3F980000};
        vecs[3]  = '{"add_small",    32'h0986AB68, 32'h10385BA9, 32'h10385FDE};
        vecs[4]  = '{"sub_10m3",     32'h41200000, 32'hC0400000, 32'h40E00000};
        vecs[5]  = '{"sub_m3p10",    32'hC0400000, 32'h41200000, 32'h40E00000};
        vecs[6]  = '{"cancel",       32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[7]  = '{"sub_ulp",      32'h3F800001, 32'hBF800000, 32'h34000000};
        vecs[8]  = '{"tie_even",     32'h4B800000, 32'h3F800000, 32'h4B800000};
        vecs[9]  = '{"tie_up",       32'h4B800001, 32'h3F800000, 32'h4B800002};
        vecs[10] = '{"inf_minus",    32'h7F800000, 32'hFF800000, 32'h7FC00000};
        vecs[11] = '{"nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000};
        vecs[12] = '{"inf_fin",      32'h7F800000, 32'h3F800000, 32'h7F800000};
        vecs[13] = '{"ovf",          32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        vecs[14] = '{"denorm",       32'h00000001, 32'h3F800000, 32'h3F800000};
        vecs[15] = '{"pz_nz",        32'h00000000, 32'h80000000, 32'h00000000};
        vecs[16] = '{"nz_nz",        32'h80000000, 32'h80000000, 32'h80000000};
        vecs[17] = '{"ninf_fin",     32'h40000000, 32'hFF800000, 32'hFF800000};
        vecs[18] = '{"nan_b",        32'h3F800000, 32'hFFC12345, 32'h7FC00000};

        // Reset and initial state
        repeat (2) @(posedge clk);
        #1 check("reset_hold", 32'h0);
        rst_n = 1'b1;

        // Table: one en pulse, capture on the next edge, then hold with en=0
        foreach (vecs[i]) begin
            operand_1 = vecs[i].a;
            operand_2 = vecs[i].b;
            en = 1'b1;
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].exp);
            en = 1'b0;
            operand_1 = 32'h40400000;
            operand_2 = 32'h40400000;
            @(posedge clk);
            #1 check({vecs[i].name, "_hold"}, vecs[i].exp);
        end

        // Back-to-back: en held high, a new result every cycle
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            operand_1 = vecs[i].a;
            operand_2 = vecs[i].b;
            @(posedge clk);
            #1 check({"b2b_", vecs[i].name}, vecs[i].exp);
        end

        // Async reset mid-run with en still high clears immediately
        operand_1 = 32'h40400000;
        operand_2 = 32'h41200000;
        #1 rst_n = 1'b0;
        #1 check("async_rst", 32'h0);
        @(posedge clk);
        #1 check("rst_en_high", 32'h0);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("post_rst_hold", 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_adder.md
Name: fp_adder

Overview:
- IEEE-754 single-precision (binary32) floating-point adder, used as the arithmetic core of the fpa controller.
- The controller loads two operands from ROM, pulses `en`, and writes `sum` to RAM one cycle later.
- Fully combinational align/add/normalize/round datapath feeding one output register.
- The register loads only when `en` is high.

Parameters:
- None. Format is fixed to binary32: 1 sign, 8 exponent, 23 fraction bits, bias 127.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- operand_1  input  32  binary32 operand A
- operand_2  input  32  binary32 operand B
- en  input  1  load enable; result of the current operands is captured at this edge
- sum  output  32  registered binary32 result A+B

Behaviour:
- Clocking and reset: one clock (`clk`); reset is asynchronous and active-low (`rst_n`).
- While `rst_n`=0, `sum` = 32'h00000000.
- Load/hold: at a rising edge with `en`=1, `sum` <= round(operand_1 + operand_2). With `en`=0, `sum` holds.
- Latency: 1 cycle. Back-to-back `en` gives one result per cycle. No handshake and no busy state.
- Operands only need to be stable at the sampling edge.
- Input classification, per operand:
  - exp=0: treated as zero. Denormals are flushed to signed zero.
  - exp=255 with frac≠0: NaN.
  - exp=255 with frac=0: infinity.
  - otherwise: normal, with hidden 1 prepended.
- Special results:
  - any NaN, or +inf + -inf: 32'h7FC00000 (canonical quiet NaN).
  - inf + finite: that inf.
  - inf + same-sign inf: that inf.
  - zero + x: x (after denormal flush).
  - +0 + -0: +0; -0 + -0: -0.
- Datapath for normal operands:
  - Swap so the larger magnitude (compare {exp,frac}) is operand L.
  - Right-shift S's 24-bit significand by dE = eL - eS. Keep guard, round and sticky bits; sticky = OR of all bits shifted past round.
  - If dE ≥ 26, S contributes only sticky.
  - Same signs: add significands. On carry-out, shift right 1 (fold the LSB into sticky) and eL+1.
  - Different signs: subtract S from L. Normalize left by the leading-zero count of the 27-bit result (significand+G+R+S) and decrement the exponent.
  - Exact cancellation gives +0.
- Rounding: round-to-nearest-even on guard/round/sticky. If rounding overflows the mantissa, renormalize and increment the exponent.
- Result sign = sign of L.
- Overflow: exponent ≥ 255 after rounding gives signed infinity (exp=255, frac=0).
- Underflow: exponent ≤ 0 after normalization gives signed zero (flush-to-zero). No denormal outputs.
- No exception flags are produced.

Decomposition:
- Shared package fp32_pkg:
  - field widths: EXP_W=8, FRAC_W=23, BIAS=127
  - constants: QNAN=32'h7FC00000, POS_INF=32'h7F800000, NEG_INF=32'hFF800000
  - classification function `is_nan` / `is_inf` / `is_zero`
- One sub-module, fp_lzc27: combinational 27-bit leading-zero counter, 5-bit output, used by the subtract normalization.
- Alignment, add/sub, rounding and the output register live in fp_adder.

Test Plan:
- Reset: assert rst_n=0 mid-run with en=1 → sum=32'h00000000 immediately. After release with en=0, sum stays 0.
- Exact adds, one en pulse each; sum valid on the cycle after the sampled edge, then held with en=0:
  - 3F800000+3C449BA6 → 3F818937
  - 40400000+41200000 → 41500000
  - 3EA00000+3F600000 → 3F980000
  - 0986AB68+10385BA9 → 10385FDE
- Subtraction/cancellation:
  - 41200000+C0400000 → 40E00000
  - 3F800000+BF800000 → 00000000
  - 3F800001+BF800000 → 34000000
- Rounding ties: 4B800000+3F800000 → 4B800000 (tie to even). 4B800001+3F800000 → 4B800002.
- Specials:
  - 7F800000+FF800000 → 7FC00000
  - 7FC00001+3F800000 → 7FC00000
  - 7F800000+3F800000 → 7F800000
  - 7F7FFFFF+7F7FFFFF → 7F800000
  - 00000001+3F800000 → 3F800000 (denormal flush)
- Back-to-back: en held high for 4 cycles with new operands each cycle → 4 consecutive correct results, each 1 cycle after its operands.
